sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
Two-master to one-slave arbiter between the Ibex instruction/data ports and the single-port SRAM (ram_1p, one-cycle read latency).
Replaces ad-hoc glue logic with a protocol-correct req/gnt/rvalid bridge.
- Grants at most one access per cycle, with round-robin or fixed priority.
- Tracks which master owns the in-flight response.
- Returns an error response for addresses outside the SRAM window.
- Flags SRAM response protocol violations.

Parameters:
MemStart, 32'h00000000, base byte address of the SRAM window
MemSize, 65536, SRAM size in bytes; power of two, at least 4
InstrPriority, 0, 0 = round-robin between masters; 1 = instruction port always wins

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
instr_req_i  in  1  instruction fetch request
instr_addr_i  in  32  instruction byte address
instr_gnt_o  out  1  instruction request accepted this cycle
instr_rvalid_o  out  1  instruction response valid
instr_rdata_o  out  32  instruction read data
instr_err_o  out  1  instruction access error (valid with rvalid)
data_req_i  in  1  data request
data_we_i  in  1  data write enable
data_be_i  in  4  data byte enables
data_addr_i  in  32  data byte address
data_wdata_i  in  32  data write data
data_gnt_o  out  1  data request accepted this cycle
data_rvalid_o  out  1  data response valid (reads and writes)
data_rdata_o  out  32  data read data
data_err_o  out  1  data access error (valid with rvalid)
mem_req_o  out  1  SRAM request
mem_we_o  out  1  SRAM write enable
mem_be_o  out  4  SRAM byte enables
mem_addr_o  out  32  SRAM byte address
mem_wdata_o  out  32  SRAM write data
mem_rvalid_i  in  1  SRAM response valid, one cycle after mem_req_o
mem_rdata_i  in  32  SRAM read data
mem_proto_err_o  out  1  sticky flag: SRAM response missing or unexpected

Behaviour:
- Reset (rst_i high, asynchronous): all registered state clears.
  - rvalid, err and rdata outputs read 0; mem_proto_err_o reads 0.
  - Last-winner register resets to "data", so the first contended cycle goes to instr.
  - gnt_o and mem_req_o are forced to 0 while rst_i is high.
- In-range test: (addr & ~(MemSize-1)) == MemStart.
- Grant (combinational, same cycle as request):
  - Single requester: it is granted.
  - Both requesting, InstrPriority=1: instr wins.
  - Both requesting, InstrPriority=0: the master that did not win the previous contended cycle wins.
  - The last-winner register updates only on contended cycles.
  - Exactly one gnt per cycle at most; the loser holds its request and is granted later.
- Granted and in-range: mem_req_o=1; mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o come from the winner.
  - For instr: we=0, be=4'hF, wdata=0.
- Granted and out-of-range: mem_req_o=0, and an error response is scheduled.
- When mem_req_o=0, all mem_* outputs are driven 0.
- Response register (resp_valid_q, resp_owner_q, resp_err_q) loads on every grant; response latency is exactly 1 cycle after gnt.
- Cycle after grant:
  - The owner's rvalid_o=1.
  - rdata_o = mem_rdata_i if no error, else 32'h0; err_o = resp_err_q.
  - The non-owner's rvalid_o=0 and its rdata_o=0.
  - Writes also get rvalid with rdata=0.
- Back-to-back grants every cycle are supported; a response and a new grant coexist in the same cycle.
- Protocol check: mem_proto_err_o sets and stays set until reset when either of these occurs:
  - mem_rvalid_i=0 in a cycle where an in-range response is expected;
  - mem_rvalid_i=1 when none is expected.
  - The response is still delivered to the master regardless.
- Reset mid-transaction: the pending response is dropped and no rvalid is issued after reset release.

Test Plan:
- Instr-only read: instr_req_i=1, addr=0x80, SRAM returns 0x00000013 -> instr_gnt_o=1 in cycle 0; instr_rvalid_o=1 with rdata 0x00000013 in cycle 1; data_rvalid_o=0.
- Contention, round-robin: both req held 4 cycles -> grants alternate instr, data, instr, data; each rvalid follows its own gnt by 1 cycle. With InstrPriority=1 -> instr granted all 4 cycles.
- Data write: addr=0x1000, we=1, be=4'b0011, wdata=0xDEADBEEF -> mem_req_o=1 with the same fields in cycle 0; data_rvalid_o=1, data_rdata_o=0, data_err_o=0 in cycle 1.
- Out-of-range: data read at 0x00010000 (MemSize 64 kB) -> data_gnt_o=1, mem_req_o=0; next cycle data_rvalid_o=1, data_err_o=1, data_rdata_o=0; mem_proto_err_o stays 0.
- Protocol error: in-range read granted, SRAM model withholds mem_rvalid_i -> mem_proto_err_o=1 from that cycle, held until rst_i.
- Reset mid-op: assert rst_i in the cycle after a grant -> instr_rvalid_o=0 immediately; no rvalid after release; first contended cycle after release grants instr.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Bridges the Ibex instruction and data req/gnt/rvalid ports onto a single
//   one-cycle-latency single-port SRAM. At most one master is granted per
//   cycle, using round-robin or fixed instruction priority. Accesses outside
//   the SRAM window are answered locally with an error response. Missing or
//   unexpected SRAM responses raise a sticky protocol-error flag.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   instr_*                   instruction master (read-only) req/gnt/rvalid port
//   data_*                    data master req/gnt/rvalid port (reads and writes)
//   mem_*                     SRAM request outputs and response inputs
//   mem_proto_err_o           sticky SRAM response protocol violation flag
module sram_bus_arbiter #(
  parameter logic [31:0] MemStart      = 32'h0000_0000,
  parameter int unsigned MemSize       = 65536,
  parameter bit          InstrPriority = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_proto_err_o
);

  localparam logic [31:0] AddrMask = ~(32'(MemSize) - 32'd1);

  function automatic logic in_window(input logic [31:0] addr);
    return (addr & AddrMask) == MemStart;
  endfunction

  // Arbitration state: 1 means the data port won the last contended cycle.
  logic last_data_q;

  // Response register: loaded on every grant, consumed the following cycle.
  logic resp_valid_q;
  logic resp_owner_q;  // 1 = data port owns the response
  logic resp_err_q;
  logic resp_we_q;
  logic proto_err_q;

  logic contended;
  logic instr_wins;
  logic gnt_any;
  logic sel_data;
  logic [31:0] sel_addr;
  logic sel_in_range;
  logic proto_violation;
  logic [31:0] resp_data;

  // Stage 0: combinational arbitration and SRAM request
  always_comb begin
    contended  = instr_req_i & data_req_i;
    // Round-robin: the master that did not win the previous contended cycle.
    instr_wins = InstrPriority ? 1'b1 : last_data_q;

    instr_gnt_o = ~rst_i & instr_req_i & (~data_req_i | instr_wins);
    data_gnt_o  = ~rst_i & data_req_i & (~instr_req_i | ~instr_wins);
    gnt_any     = instr_gnt_o | data_gnt_o;
    sel_data    = data_gnt_o;

    sel_addr     = sel_data ? data_addr_i : instr_addr_i;
    sel_in_range = in_window(sel_addr);

    mem_req_o   = gnt_any & sel_in_range;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (mem_req_o) begin
      mem_addr_o = sel_addr;
      if (sel_data) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o = 4'hF;
      end
    end
  end

  // Stage 0 -> 1: grant state captured for the response cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_data_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_we_q    <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      if (contended) begin
        last_data_q <= data_gnt_o;
      end
      resp_valid_q <= gnt_any;
      resp_owner_q <= sel_data;
      resp_err_q   <= gnt_any & ~sel_in_range;
      resp_we_q    <= sel_data & data_we_i;
      if (proto_violation) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Stage 1: response routing and protocol check
  always_comb begin
    // An SRAM response is expected exactly when the previous grant reached the SRAM.
    proto_violation = ~rst_i &
                      ((resp_valid_q & ~resp_err_q) ? ~mem_rvalid_i : mem_rvalid_i);
    // Visible in the violating cycle, then held by the sticky register.
    mem_proto_err_o = proto_err_q | proto_violation;

    resp_data = (resp_valid_q & ~resp_err_q & ~resp_we_q) ? mem_rdata_i : 32'h0;

    instr_rvalid_o = resp_valid_q & ~resp_owner_q;
    instr_err_o    = instr_rvalid_o & resp_err_q;
    instr_rdata_o  = instr_rvalid_o ? resp_data : 32'h0;

    data_rvalid_o  = resp_valid_q & resp_owner_q;
    data_err_o     = data_rvalid_o & resp_err_q;
    data_rdata_o   = data_rvalid_o ? resp_data : 32'h0;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_proto_err_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;

  // Fixed-priority instance sharing the same stimulus
  logic        p_instr_gnt_o, p_instr_rvalid_o, p_instr_err_o;
  logic [31:0] p_instr_rdata_o;
  logic        p_data_gnt_o, p_data_rvalid_o, p_data_err_o;
  logic [31:0] p_data_rdata_o;
  logic        p_mem_req_o, p_mem_we_o, p_mem_proto_err_o;
  logic [3:0]  p_mem_be_o;
  logic [31:0] p_mem_addr_o, p_mem_wdata_o;

  int errors = 0;
  int checks = 0;

  logic        withhold = 1'b0;
  logic [31:0] rd_val   = 32'h0;

  always #5 clk_i = ~clk_i;

  sram_bus_arbiter #(.MemStart(32'h0), .MemSize(65536), .InstrPriority(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_proto_err_o(mem_proto_err_o)
  );

  sram_bus_arbiter #(.MemStart(32'h0), .MemSize(65536), .InstrPriority(1'b1)) dut_prio (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(p_instr_gnt_o),
    .instr_rvalid_o(p_instr_rvalid_o), .instr_rdata_o(p_instr_rdata_o), .instr_err_o(p_instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(p_data_gnt_o),
    .data_rvalid_o(p_data_rvalid_o), .data_rdata_o(p_data_rdata_o), .data_err_o(p_data_err_o),
    .mem_req_o(p_mem_req_o), .mem_we_o(p_mem_we_o), .mem_be_o(p_mem_be_o), .mem_addr_o(p_mem_addr_o),
    .mem_wdata_o(p_mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_proto_err_o(p_mem_proto_err_o)
  );

  // SRAM model: one-cycle response to the primary instance's requests
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= 32'h0;
    end else begin
      mem_rvalid_i <= mem_req_o & ~withhold;
      mem_rdata_i  <= rd_val;
    end
  end

  task automatic idle();
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    @(negedge clk_i);
    instr_req_i = 1'b1;
    data_req_i  = 1'b1;
    #1;
    checks++;
    if (instr_gnt_o !== 1'b0 || data_gnt_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: gnt i/d=%b/%b mem_req=%b, required 0/0/0", instr_gnt_o, data_gnt_o, mem_req_o);
    end
    checks++;
    if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h0 ||
        data_rdata_o !== 32'h0 || mem_proto_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: rvalid i/d=%b/%b rdata i/d=%h/%h proto=%b, required all 0",
               instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o, mem_proto_err_o);
    end
    idle();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_instr_read();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h80;
    rd_val       = 32'h0000_0013;
    #1;
    checks++;
    if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h80 ||
        mem_we_o !== 1'b0 || mem_be_o !== 4'hF || mem_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL instr_req: gnt=%b req=%b addr=%h we=%b be=%h wd=%h, required 1 1 00000080 0 f 0",
               instr_gnt_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
    end
    @(negedge clk_i);
    idle();
    #1;
    checks++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h0000_0013 || instr_err_o !== 1'b0 ||
        data_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL instr_resp: rvalid=%b rdata=%h err=%b d_rvalid=%b, required 1 00000013 0 0",
               instr_rvalid_o, instr_rdata_o, instr_err_o, data_rvalid_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_contention();
    logic exp_i;
    logic prev_i;
    prev_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h100 + 32'(4 * k);
      data_req_i   = 1'b1;
      data_addr_i  = 32'h2000 + 32'(4 * k);
      rd_val       = 32'hA000 + 32'(k);
      #1;
      exp_i = (k % 2) == 0;
      checks++;
      if (instr_gnt_o !== exp_i || data_gnt_o !== !exp_i) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: gnt i/d=%b/%b, required %b/%b", k, instr_gnt_o, data_gnt_o, exp_i, !exp_i);
      end
      checks++;
      if (p_instr_gnt_o !== 1'b1 || p_data_gnt_o !== 1'b0) begin
        errors++;
        $display("FAIL prio_gnt[%0d]: gnt i/d=%b/%b, required 1/0", k, p_instr_gnt_o, p_data_gnt_o);
      end
      if (k > 0) begin
        checks++;
        if (instr_rvalid_o !== prev_i || data_rvalid_o !== !prev_i ||
            (prev_i ? instr_rdata_o : data_rdata_o) !== 32'hA000 + 32'(k - 1)) begin
          errors++;
          $display("FAIL rr_resp[%0d]: rvalid i/d=%b/%b rdata i/d=%h/%h, required %b/%b data %h",
                   k, instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o, prev_i, !prev_i,
                   32'hA000 + 32'(k - 1));
        end
      end
      prev_i = exp_i;
      @(negedge clk_i);
    end
    idle();
    #1;
    checks++;
    if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hA003) begin
      errors++;
      $display("FAIL rr_resp_last: rvalid i/d=%b/%b rdata=%h, required 0/1 0000a003",
               instr_rvalid_o, data_rvalid_o, data_rdata_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_data_write();
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'b0011;
    data_addr_i  = 32'h1000;
    data_wdata_i = 32'hDEAD_BEEF;
    rd_val       = 32'h5555_AAAA;
    #1;
    checks++;
    if (data_gnt_o !== 1'b1 || mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0011 ||
        mem_addr_o !== 32'h1000 || mem_wdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_req: gnt=%b req=%b we=%b be=%h addr=%h wd=%h, required 1 1 1 3 00001000 deadbeef",
               data_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    @(negedge clk_i);
    idle();
    #1;
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h0 || data_err_o !== 1'b0 ||
        instr_rvalid_o !== 1'b0 || mem_proto_err_o !== 1'b0) begin
      errors++;
      $display("FAIL write_resp: rvalid=%b rdata=%h err=%b i_rvalid=%b proto=%b, required 1 0 0 0 0",
               data_rvalid_o, data_rdata_o, data_err_o, instr_rvalid_o, mem_proto_err_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_out_of_range();
    data_req_i  = 1'b1;
    data_addr_i = 32'h0001_0000;
    data_be_i   = 4'hF;
    rd_val      = 32'h1234_5678;
    #1;
    checks++;
    if (data_gnt_o !== 1'b1 || mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_be_o !== 4'h0) begin
      errors++;
      $display("FAIL oor_req: gnt=%b mem_req=%b addr=%h be=%h, required 1 0 0 0",
               data_gnt_o, mem_req_o, mem_addr_o, mem_be_o);
    end
    @(negedge clk_i);
    idle();
    #1;
    checks++;
    if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || data_rdata_o !== 32'h0 ||
        mem_proto_err_o !== 1'b0) begin
      errors++;
      $display("FAIL oor_resp: rvalid=%b err=%b rdata=%h proto=%b, required 1 1 0 0",
               data_rvalid_o, data_err_o, data_rdata_o, mem_proto_err_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (data_rvalid_o !== 1'b0 || mem_proto_err_o !== 1'b0) begin
      errors++;
      $display("FAIL oor_after: rvalid=%b proto=%b, required 0 0", data_rvalid_o, mem_proto_err_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_proto_err();
    withhold     = 1'b1;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h40;
    rd_val       = 32'h0;
    #1;
    checks++;
    if (mem_proto_err_o !== 1'b0) begin
      errors++;
      $display("FAIL proto_pre: proto=%b, required 0", mem_proto_err_o);
    end
    @(negedge clk_i);
    idle();
    withhold = 1'b0;
    #1;
    checks++;
    if (mem_proto_err_o !== 1'b1 || instr_rvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL proto_set: proto=%b rvalid=%b, required 1 1", mem_proto_err_o, instr_rvalid_o);
    end
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (mem_proto_err_o !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky: proto=%b, required 1", mem_proto_err_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h200;
    rd_val       = 32'hCAFE_0001;
    #1;
    checks++;
    if (instr_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_gnt: gnt=%b, required 1", instr_gnt_o);
    end
    @(negedge clk_i);
    idle();
    rst_i = 1'b1;
    #1;
    checks++;
    if (instr_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h0 || mem_proto_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop: rvalid=%b rdata=%h proto=%b, required 0 0 0",
               instr_rvalid_o, instr_rdata_o, mem_proto_err_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;
    checks++;
    if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || mem_proto_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: rvalid i/d=%b/%b proto=%b, required 0/0 0",
               instr_rvalid_o, data_rvalid_o, mem_proto_err_o);
    end
    @(negedge clk_i);
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h300;
    data_req_i   = 1'b1;
    data_addr_i  = 32'h400;
    #1;
    checks++;
    if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_first_contend: gnt i/d=%b/%b, required 1/0", instr_gnt_o, data_gnt_o);
    end
    @(negedge clk_i);
    idle();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    test_reset();
    test_instr_read();
    test_contention();
    test_data_write();
    test_out_of_range();
    test_proto_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
